fpcvt_seq: RTL and testbench
============================

FPCVT_SEQ -- requirements
Module: fpcvt_seq

Interface
REQ-001 SHALL have parameter EW, default 3, exponent width.
REQ-002 SHALL have parameter MW, default 4, significand width.
REQ-003 SHALL derive localparams DW = 2**EW + MW (input width, 12 by default) and E_MAX = 2**EW - 1.
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port in_valid  input  1  in_data valid.
REQ-007 SHALL have port in_ready  output  1  block can accept a sample.
REQ-008 SHALL have port in_data  input  DW  two's-complement sample.
REQ-009 SHALL have port out_valid  output  1  result valid.
REQ-010 SHALL have port out_ready  input  1  consumer accepts result.
REQ-011 SHALL have port out_s  output  1  sign.
REQ-012 SHALL have port out_e  output  EW  exponent.
REQ-013 SHALL have port out_f  output  MW  significand; value = out_f * 2**out_e.

Function
REQ-014 SHALL implement a four-state FSM: IDLE, NORM, ROUND, OUT.
REQ-015 SHALL drive in_ready = 1 only in IDLE, and out_valid = 1 only in OUT.
REQ-016 On an IDLE edge with in_valid=1: SHALL capture S = in_data[DW-1], M = |in_data| (DW bits unsigned), E = E_MAX, then go to NORM.
REQ-017 SHALL flag saturation at capture when M[DW-1]=1 (only for in_data = -2**(DW-1)).
REQ-018 NORM edge: if E>0 and M[DW-2]=0, SHALL shift M left 1, decrement E, and stay; otherwise go to ROUND. At most E_MAX shifts.
REQ-019 ROUND edge: SHALL set F = M[DW-2:DW-1-MW] and round bit R = M[DW-2-MW], round half-up by adding R to F, then go to OUT.
REQ-020 If rounding overflows F: SHALL set F = 2**(MW-1) and E = E+1.
REQ-021 If E would exceed E_MAX, or the saturation flag is set: SHALL output E = E_MAX and F = all ones.
REQ-022 Latency: for n shifts, out_valid SHALL rise n+3 edges after the input handshake edge (min 3, max E_MAX+3).
REQ-023 In OUT: out_s, out_e, out_f SHALL hold stable until an edge with out_ready=1, then go to IDLE.
REQ-024 in_valid SHALL be ignored outside IDLE; no input buffering.
REQ-025 Zero input SHALL produce S=0, E=0, F=0 after E_MAX shifts.

Reset
REQ-026 rst_n=0 SHALL asynchronously force IDLE, in_ready=1, out_valid=0, out_s=0, out_e=0, out_f=0, and clear internal M, E and the saturation flag.
REQ-027 Reset asserted mid-conversion SHALL abort the conversion with no output.
REQ-028 The first handshake SHALL be accepted on the first rising edge after rst_n deasserts.

Configuration
REQ-029 Macro FPCVT_SEQ_STATUS_EN defined: SHALL add outputs out_sat (1 bit, the REQ-021 saturation case) and out_inexact (1 bit, set when saturated or when R or any of M[DW-3-MW:0] is nonzero at ROUND). Both are valid with out_valid and reset to 0.
REQ-030 Macro undefined: those ports and their logic SHALL be absent; all other behaviour identical.

Verification (default parameters)
REQ-031 in_data=12'b010110011001 -> S=0, E=111, F=1011; out_valid 3 edges after handshake.
REQ-032 in_data=12'b101001110010 -> S=1, E=111, F=1011. in_data=12'b100000000000 -> S=1, E=111, F=1111, out_sat=1.
REQ-033 in_data=12'b001111100000 -> round overflow, S=0, E=111, F=1000, latency 4. in_data=12'b011111111111 -> S=0, E=111, F=1111, out_sat=1.
REQ-034 in_data=12'b000000001101 -> S=0, E=000, F=1101, latency 10, out_inexact=0.
REQ-035 Hold out_ready=0 for 5 cycles in OUT -> outputs stable and in_ready=0. Then out_ready=1 -> IDLE, and the next sample is accepted on the following edge.
REQ-036 Assert rst_n=0 during NORM -> outputs zero immediately; no stale result after release.

Source files
------------

// File: rtl/fpcvt_seq.sv
// Sequential two's-complement to sign/exponent/significand converter (normalize, round half-up, saturate).
// Optional status outputs out_sat/out_inexact are enabled by defining FPCVT_SEQ_STATUS_EN.
module fpcvt_seq #(
  parameter int EW = 3,
  parameter int MW = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [2**EW+MW-1:0]    in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_s,
  output logic [EW-1:0]          out_e,
  output logic [MW-1:0]          out_f
`ifdef FPCVT_SEQ_STATUS_EN
  ,
  output logic                   out_sat,
  output logic                   out_inexact
`endif
);

  localparam int DW = 2**EW + MW;
  localparam logic [EW-1:0] E_MAX = EW'(2**EW - 1);
  localparam logic [MW-1:0] F_OVF = {1'b1, {(MW-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, NORM, ROUND, OUT} state_t;

  state_t                r_state, w_next;
  logic                  r_s, r_sat;
  logic [DW-1:0]         r_m;
  logic [EW-1:0]         r_e;
  logic                  r_out_s;
  logic [EW-1:0]         r_out_e;
  logic [MW-1:0]         r_out_f;

  logic signed [DW-1:0]  w_in;
  logic [DW-1:0]         w_abs;
  logic                  w_shift;
  logic [MW:0]           w_sum;
  logic                  w_satd;
  logic [EW-1:0]         w_e_rnd;
  logic [MW-1:0]         w_f_rnd;

  // Significand plus round bit; the extra MSB is the rounding carry-out.
  function automatic logic [MW:0] round_half_up(input logic [DW-1:0] m);
    return {1'b0, m[DW-2 -: MW]} + {{MW{1'b0}}, m[DW-2-MW]};
  endfunction

  function automatic logic saturates(input logic carry, input logic [EW-1:0] e, input logic sat);
    return sat | (carry & (e == E_MAX));
  endfunction

  assign w_in    = signed'(in_data);
  assign w_abs   = w_in[DW-1] ? unsigned'(-w_in) : unsigned'(w_in);
  assign w_shift = (r_e != '0) && !r_m[DW-2];
  assign w_sum   = round_half_up(r_m);
  assign w_satd  = saturates(w_sum[MW], r_e, r_sat);
  assign w_e_rnd = w_satd ? E_MAX : (w_sum[MW] ? r_e + 1'b1 : r_e);
  assign w_f_rnd = w_satd ? '1 : (w_sum[MW] ? F_OVF : w_sum[MW-1:0]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (in_valid)  w_next = NORM;
      NORM:    if (!w_shift)  w_next = ROUND;
      ROUND:                  w_next = OUT;
      OUT:     if (out_ready) w_next = IDLE;
      default:                w_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (r_state == IDLE);
    out_valid = (r_state == OUT);
  end

  // Capture / normalize / round datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s     <= 1'b0;
      r_sat   <= 1'b0;
      r_m     <= '0;
      r_e     <= '0;
      r_out_s <= 1'b0;
      r_out_e <= '0;
      r_out_f <= '0;
    end else begin
      case (r_state)
        IDLE: if (in_valid) begin
          r_s   <= in_data[DW-1];
          r_m   <= w_abs;
          r_e   <= E_MAX;
          r_sat <= w_abs[DW-1];
        end
        NORM: if (w_shift) begin
          r_m <= r_m << 1;
          r_e <= r_e - 1'b1;
        end
        ROUND: begin
          r_out_s <= r_s;
          r_out_e <= w_e_rnd;
          r_out_f <= w_f_rnd;
        end
        default: ;
      endcase
    end
  end

  assign out_s = r_out_s;
  assign out_e = r_out_e;
  assign out_f = r_out_f;

`ifdef FPCVT_SEQ_STATUS_EN
  logic r_out_sat, r_out_inexact;

  // Inexact covers the round bit and every bit below it, or any saturation.
  function automatic logic inexact(input logic [DW-1:0] m, input logic satd);
    return satd | (|m[DW-2-MW:0]);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_sat     <= 1'b0;
      r_out_inexact <= 1'b0;
    end else if (r_state == ROUND) begin
      r_out_sat     <= w_satd;
      r_out_inexact <= inexact(r_m, w_satd);
    end
  end

  assign out_sat     = r_out_sat;
  assign out_inexact = r_out_inexact;
`endif

endmodule

// File: tb/tb_fpcvt_seq.sv
// Self-checking bench for fpcvt_seq: directed vectors, randomized samples against an arithmetic model,
// backpressure hold, and asynchronous reset abort.
module tb_fpcvt_seq;
  localparam int EW = 3;
  localparam int MW = 4;
  localparam int DW = 12;
  localparam int E_MAX = 7;

  logic clk = 1'b0;
  logic rst_n;
  logic in_valid, in_ready, out_valid, out_ready, out_s;
  logic [DW-1:0] in_data;
  logic [EW-1:0] out_e;
  logic [MW-1:0] out_f;
`ifdef FPCVT_SEQ_STATUS_EN
  logic out_sat, out_inexact;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fpcvt_seq #(.EW(EW), .MW(MW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_s(out_s), .out_e(out_e), .out_f(out_f)
`ifdef FPCVT_SEQ_STATUS_EN
    , .out_sat(out_sat), .out_inexact(out_inexact)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: value = f * 2**e, normalized to the largest exponent <= E_MAX.
  task automatic model(input logic [DW-1:0] x, output int s, output int e, output int f,
                       output int sat, output int inex, output int lat);
    int v, m, n;
    v = int'($signed(x));
    s = (v < 0) ? 1 : 0;
    m = (v < 0) ? -v : v;
    sat = (m >= 2048) ? 1 : 0;
    e = E_MAX;
    n = 0;
    while (e > 0 && (m & 1024) == 0) begin
      m = (m * 2) % 4096;
      e--;
      n++;
    end
    f = (m / 128) % 16 + (m / 64) % 2;
    inex = (sat != 0 || (m % 128) != 0) ? 1 : 0;
    if (f == 16) begin
      f = 8;
      e++;
    end
    if (e > E_MAX) sat = 1;
    if (sat != 0) begin
      e = E_MAX;
      f = 15;
    end
    lat = n + 3;
  endtask

  task automatic do_conv(input logic [DW-1:0] x, input int hold, input int es, input int ee,
                         input int ef, input int esat, input int einex, input int elat);
    int k;
    check("in_ready_idle", in_ready, 1);
    in_valid = 1'b1;
    in_data  = x;
    @(posedge clk); #1;
    k = 1;
    while (!out_valid && k < 40) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_data   = DW'($urandom);
      out_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      k++;
    end
    out_ready = 1'b0;
    check("latency", k, elat);
    check("out_s", out_s, es);
    check("out_e", out_e, ee);
    check("out_f", out_f, ef);
`ifdef FPCVT_SEQ_STATUS_EN
    check("out_sat", out_sat, esat);
    check("out_inexact", out_inexact, einex);
`else
    if (esat < 0 || einex < 0) check("status_args", 0, 1);
`endif
    check("in_ready_busy", in_ready, 0);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      check("hold_valid", out_valid, 1);
      check("hold_in_ready", in_ready, 0);
      check("hold_e", out_e, ee);
      check("hold_f", out_f, ef);
      check("hold_s", out_s, es);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("drain_valid", out_valid, 0);
    check("drain_in_ready", in_ready, 1);
  endtask

  task automatic run_model(input logic [DW-1:0] x, input int hold);
    int s, e, f, sat, inex, lat;
    model(x, s, e, f, sat, inex, lat);
    do_conv(x, hold, s, e, f, sat, inex, lat);
  endtask

  initial begin
    logic [DW-1:0] x;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    #12;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_s", out_s, 0);
    check("rst_out_e", out_e, 0);
    check("rst_out_f", out_f, 0);
    @(negedge clk);
    rst_n = 1'b1;

    do_conv(12'b010110011001, 0, 0, 7, 11, 0, 1, 3);
    do_conv(12'b101001110010, 0, 1, 7, 11, 0, 1, 3);
    do_conv(12'b100000000000, 0, 1, 7, 15, 1, 1, 10);
    do_conv(12'b001111100000, 0, 0, 7, 8, 0, 1, 4);
    do_conv(12'b011111111111, 0, 0, 7, 15, 1, 1, 3);
    do_conv(12'b000000001101, 0, 0, 0, 13, 0, 0, 10);
    do_conv(12'b000000000000, 0, 0, 0, 0, 0, 0, 10);
    do_conv(12'b111111111111, 5, 1, 0, 1, 0, 0, 10);
    do_conv(12'b010110011001, 0, 0, 7, 11, 0, 1, 3);

    for (int i = 0; i < 40; i++) begin
      x = DW'($urandom) >> $urandom_range(0, 11);
      if ($urandom_range(0, 1) == 1) x = -x;
      run_model(x, $urandom_range(0, 2));
    end

    // Abort a conversion mid-normalization; the last result above is nonzero.
    run_model(12'b011011000111, 0);
    in_valid = 1'b1;
    in_data  = 12'b000000001101;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("abort_out_valid", out_valid, 0);
    check("abort_in_ready", in_ready, 1);
    check("abort_out_s", out_s, 0);
    check("abort_out_e", out_e, 0);
    check("abort_out_f", out_f, 0);
`ifdef FPCVT_SEQ_STATUS_EN
    check("abort_out_sat", out_sat, 0);
    check("abort_out_inexact", out_inexact, 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      check("no_stale_valid", out_valid, 0);
    end
    run_model(12'b000001010110, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
